// File: rtl/seg_pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_pipe_ctrl_pkg
// Description : Shared encodings for the five-segment pipeline controller:
//               controller states, segment indices and forwarding selects.
// Revision    : 1.0 - initial release
// ============================================================================
package seg_pipe_ctrl_pkg;

    // Controller state encoding (also driven out on the state port)
    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_RUN      = 2'b01,
        ST_DRAIN    = 2'b10,
        ST_HALT_ERR = 2'b11
    } state_e;

    // Segment indices into seg_en / seg_vld
    localparam int NSEG    = 5;
    localparam int SEG_IF  = 0;
    localparam int SEG_ID  = 1;
    localparam int SEG_EX  = 2;
    localparam int SEG_MEM = 3;
    localparam int SEG_WB  = 4;

    // EX operand source selects
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EXM = 2'b01;
    localparam logic [1:0] FWD_MWB = 2'b10;

endpackage
`default_nettype wire

// File: rtl/seg_pipe_ctrl_hazard_det.sv
`default_nettype none
// ============================================================================
// Module      : seg_hazard_det
// Description : Combinational RAW hazard detection for the ID instruction.
//               Produces the data-stall request and the EX operand forwarding
//               selects. Build option PIPE_FWD_EN enables forwarding, leaving
//               only load-use as a stall source.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_hazard_det
    import seg_pipe_ctrl_pkg::*;
#(
    parameter int AW = 5
) (
    input  logic          id_vld_i,
    input  logic          ex_vld_i,
    input  logic          mem_vld_i,
    input  logic [AW-1:0] id_rs_i,
    input  logic [AW-1:0] id_rt_i,
    input  logic          id_use_rs_i,
    input  logic          id_use_rt_i,
    input  logic [AW-1:0] ex_rd_i,
    input  logic          ex_wr_i,
    input  logic          ex_load_i,
    input  logic [AW-1:0] mem_rd_i,
    input  logic          mem_wr_i,
    output logic          stall_o,
    output logic [1:0]    fwd_a_o,
    output logic [1:0]    fwd_b_o
);

    // Address matches of each used, non-zero ID source against valid EX / MEM
    // destinations; register 0 is hard-wired and never creates a dependency.
    logic w_rs_ex, w_rt_ex, w_rs_mem, w_rt_mem;

    assign w_rs_ex  = id_use_rs_i && (id_rs_i != '0) && ex_vld_i && (id_rs_i == ex_rd_i);
    assign w_rt_ex  = id_use_rt_i && (id_rt_i != '0) && ex_vld_i && (id_rt_i == ex_rd_i);
    assign w_rs_mem = id_use_rs_i && (id_rs_i != '0) && mem_vld_i && mem_wr_i && (id_rs_i == mem_rd_i);
    assign w_rt_mem = id_use_rt_i && (id_rt_i != '0) && mem_vld_i && mem_wr_i && (id_rt_i == mem_rd_i);

`ifdef PIPE_FWD_EN
    // A load's data is not available until after MEM, so only load-use stalls
    assign stall_o = id_vld_i && ex_load_i && (w_rs_ex || w_rt_ex);

    // Forward select per operand; the younger EX producer takes priority
    always_comb begin
        fwd_a_o = FWD_RF;
        fwd_b_o = FWD_RF;
        if (w_rs_ex && ex_wr_i) fwd_a_o = FWD_EXM;
        else if (w_rs_mem)      fwd_a_o = FWD_MWB;
        if (w_rt_ex && ex_wr_i) fwd_b_o = FWD_EXM;
        else if (w_rt_mem)      fwd_b_o = FWD_MWB;
    end
`else
    // No bypass paths: any pending EX or MEM write to a used source stalls ID
    assign stall_o = id_vld_i && (((w_rs_ex || w_rt_ex) && ex_wr_i) || w_rs_mem || w_rt_mem);
    assign fwd_a_o = FWD_RF;
    assign fwd_b_o = FWD_RF;

    logic w_unused_load;
    assign w_unused_load = ex_load_i;
`endif

endmodule
`default_nettype wire

// File: rtl/seg_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seg_pipe_ctrl
// Description : Sequencing and hazard controller for the five-segment CPU.
//               Per-segment enables on one clock, valid-bit tracking, bubbles
//               on data hazards, branch flush, memory-wait stall with timeout,
//               and clean drain on halt. Build option PIPE_FWD_EN enables
//               operand forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_pipe_ctrl
    import seg_pipe_ctrl_pkg::*;
#(
    parameter int AW    = 5,
    parameter int MEMTO = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    input  logic          halt_req,
    input  logic [AW-1:0] id_rs,
    input  logic [AW-1:0] id_rt,
    input  logic          id_use_rs,
    input  logic          id_use_rt,
    input  logic [AW-1:0] ex_rd,
    input  logic          ex_wr,
    input  logic          ex_load,
    input  logic [AW-1:0] mem_rd,
    input  logic          mem_wr,
    input  logic          ex_cond,
    input  logic          mem_req,
    input  logic          mem_ready,
    output logic [4:0]    seg_en,
    output logic [4:0]    seg_vld,
    output logic          pc_sel,
    output logic [1:0]    fwd_a,
    output logic [1:0]    fwd_b,
    output logic [1:0]    state,
    output logic          mem_timeout,
    output logic [15:0]   stall_cnt
);

    localparam int WCW = $clog2(MEMTO + 1);

    state_e          state_q, state_d;
    logic [NSEG-1:0] vld_q, vld_d;
    logic [1:0]      fwd_a_q, fwd_b_q;
    logic            timeout_q, timeout_d;
    logic [15:0]     stall_cnt_q, stall_cnt_d;
    logic [WCW-1:0]  wait_cnt_q, wait_cnt_d;

    logic            w_active, w_mem_wait, w_branch, w_data_stall;
    logic            w_halt_go, w_timeout_hit;
    logic [NSEG-1:1] w_kill;
    logic [1:0]      w_fwd_a, w_fwd_b;

    seg_hazard_det #(.AW(AW)) u_hazard (
        .id_vld_i    (vld_q[SEG_ID]),
        .ex_vld_i    (vld_q[SEG_EX]),
        .mem_vld_i   (vld_q[SEG_MEM]),
        .id_rs_i     (id_rs),
        .id_rt_i     (id_rt),
        .id_use_rs_i (id_use_rs),
        .id_use_rt_i (id_use_rt),
        .ex_rd_i     (ex_rd),
        .ex_wr_i     (ex_wr),
        .ex_load_i   (ex_load),
        .mem_rd_i    (mem_rd),
        .mem_wr_i    (mem_wr),
        .stall_o     (w_data_stall),
        .fwd_a_o     (w_fwd_a),
        .fwd_b_o     (w_fwd_b)
    );

    assign w_active   = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign w_mem_wait = vld_q[SEG_MEM] && mem_req && !mem_ready;
    assign w_branch   = vld_q[SEG_EX] && ex_cond;
    // Halt is accepted only when ID is free to advance this cycle
    assign w_halt_go  = (state_q == ST_RUN) && halt_req && vld_q[SEG_ID]
                        && !w_mem_wait && !w_branch && !w_data_stall;
    assign w_timeout_hit = w_active && w_mem_wait && (wait_cnt_q == WCW'(MEMTO - 1));

    // Segment enables, bubble kills and PC select, in hazard priority order
    always_comb begin
        seg_en = '0;
        w_kill = '0;
        pc_sel = 1'b0;
        if (w_active) begin
            if (w_mem_wait) begin
                seg_en[SEG_WB] = 1'b1;
                w_kill[SEG_WB] = 1'b1;
            end else if (w_branch) begin
                seg_en         = '1;
                pc_sel         = 1'b1;
                w_kill[SEG_ID] = 1'b1;
                w_kill[SEG_EX] = 1'b1;
            end else if (w_data_stall) begin
                seg_en[SEG_WB:SEG_EX] = '1;
                w_kill[SEG_EX]        = 1'b1;
            end else begin
                seg_en = '1;
                // Hold the PC on the halt so a later run refetches the next instruction
                if (w_halt_go) begin
                    seg_en[SEG_IF] = 1'b0;
                    w_kill[SEG_ID] = 1'b1;
                    w_kill[SEG_EX] = 1'b1;
                end
            end
            if (state_q == ST_DRAIN) seg_en[SEG_IF] = 1'b0;
        end
    end

    // Valid bits advance through enabled segments; disabled segments hold
    always_comb begin
        vld_d = vld_q;
        if (seg_en[SEG_IF])                           vld_d[SEG_IF] = (state_q == ST_RUN);
        else if ((state_q != ST_RUN) || w_halt_go)    vld_d[SEG_IF] = 1'b0;
        for (int i = 1; i < NSEG; i++) begin
            if (seg_en[i]) vld_d[i] = vld_q[i-1] && !w_kill[i];
        end
    end

    // Controller next state, memory-wait timer and stall statistics
    always_comb begin
        state_d     = state_q;
        timeout_d   = timeout_q | w_timeout_hit;
        wait_cnt_d  = (w_active && w_mem_wait) ? wait_cnt_q + 1'b1 : '0;
        stall_cnt_d = stall_cnt_q;
        if (w_active && (w_mem_wait || (w_data_stall && !w_branch)) && (stall_cnt_q != 16'hFFFF))
            stall_cnt_d = stall_cnt_q + 16'd1;
        case (state_q)
            ST_IDLE:     if (run) state_d = ST_RUN;
            ST_RUN: begin
                if (w_timeout_hit)  state_d = ST_HALT_ERR;
                else if (w_halt_go) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (w_timeout_hit || (vld_q[SEG_WB:SEG_ID] == '0)) state_d = ST_HALT_ERR;
            end
            ST_HALT_ERR: if (run && !timeout_q) state_d = ST_RUN;
            default:     state_d = ST_IDLE;
        endcase
    end

    // State, valid pipe and counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            vld_q       <= '0;
            timeout_q   <= 1'b0;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            vld_q       <= vld_d;
            timeout_q   <= timeout_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Forward selects travel with the instruction as it moves from ID into EX
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_a_q <= FWD_RF;
            fwd_b_q <= FWD_RF;
        end else if (seg_en[SEG_EX]) begin
            fwd_a_q <= w_kill[SEG_EX] ? FWD_RF : w_fwd_a;
            fwd_b_q <= w_kill[SEG_EX] ? FWD_RF : w_fwd_b;
        end
    end

    assign seg_vld     = vld_q;
    assign fwd_a       = fwd_a_q;
    assign fwd_b       = fwd_b_q;
    assign state       = state_q;
    assign mem_timeout = timeout_q;
    assign stall_cnt   = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_pipe_ctrl
// Description : Directed self-checking bench for seg_pipe_ctrl. Expected values
//               depend on whether PIPE_FWD_EN is defined for the build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_pipe_ctrl;

    localparam int AW    = 5;
    localparam int MEMTO = 8;

    logic          clk = 1'b0;
    logic          rst, run, halt_req;
    logic [AW-1:0] id_rs, id_rt, ex_rd, mem_rd;
    logic          id_use_rs, id_use_rt, ex_wr, ex_load, mem_wr;
    logic          ex_cond, mem_req, mem_ready;
    logic [4:0]    seg_en, seg_vld;
    logic          pc_sel, mem_timeout;
    logic [1:0]    fwd_a, fwd_b, state;
    logic [15:0]   stall_cnt;

    int n_pass    = 0;
    int n_total   = 0;
    int exp_stall = 0;

    seg_pipe_ctrl #(.AW(AW), .MEMTO(MEMTO)) dut (
        .clk(clk), .rst(rst), .run(run), .halt_req(halt_req),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .ex_rd(ex_rd), .ex_wr(ex_wr), .ex_load(ex_load),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .ex_cond(ex_cond),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .seg_en(seg_en), .seg_vld(seg_vld), .pc_sel(pc_sel),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .state(state),
        .mem_timeout(mem_timeout), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        run = 0; halt_req = 0; id_rs = '0; id_rt = '0; id_use_rs = 0; id_use_rt = 0;
        ex_rd = '0; ex_wr = 0; ex_load = 0; mem_rd = '0; mem_wr = 0;
        ex_cond = 0; mem_req = 0; mem_ready = 1;
        #1;
    endtask

    task automatic refill();
        clear_inputs();
        repeat (5) tick();
    endtask

    task automatic test_reset();
        rst = 1;
        clear_inputs();
        repeat (2) tick();
        n_total++; if (state !== 2'b00) $display("FAIL reset_state: got %b want 00", state); else n_pass++;
        n_total++; if (seg_vld !== 5'b0) $display("FAIL reset_vld: got %b want 00000", seg_vld); else n_pass++;
        n_total++; if (seg_en !== 5'b0) $display("FAIL reset_en: got %b want 00000", seg_en); else n_pass++;
        n_total++; if ({pc_sel, mem_timeout, fwd_a, fwd_b} !== 6'b0) $display("FAIL reset_misc: got %b want 000000", {pc_sel, mem_timeout, fwd_a, fwd_b}); else n_pass++;
        n_total++; if (stall_cnt !== 16'd0) $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); else n_pass++;
        rst = 0;
    endtask

    task automatic test_fill();
        logic [4:0] exp_vld;
        exp_vld = 5'b0;
        run = 1;
        tick();
        run = 0;
        #1;
        n_total++; if (state !== 2'b01) $display("FAIL fill_state: got %b want 01", state); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            n_total++; if (seg_en !== 5'b11111) $display("FAIL fill_en%0d: got %b want 11111", i, seg_en); else n_pass++;
            tick();
            exp_vld = {exp_vld[3:0], 1'b1};
            n_total++; if (seg_vld !== exp_vld) $display("FAIL fill_vld%0d: got %b want %b", i, seg_vld, exp_vld); else n_pass++;
        end
        tick();
        n_total++; if (stall_cnt !== 16'd0) $display("FAIL fill_stall_cnt: got %0d want 0", stall_cnt); else n_pass++;
    endtask

    task automatic test_load_use();
        ex_rd = 5'd3; ex_wr = 1; ex_load = 1; id_rs = 5'd3; id_use_rs = 1;
        #1;
        n_total++; if (seg_en !== 5'b11100) $display("FAIL lu_en: got %b want 11100", seg_en); else n_pass++;
        tick();
        exp_stall++;
        n_total++; if (seg_vld !== 5'b11011) $display("FAIL lu_vld: got %b want 11011", seg_vld); else n_pass++;
        n_total++; if (stall_cnt !== 16'(exp_stall)) $display("FAIL lu_stall_cnt: got %0d want %0d", stall_cnt, exp_stall); else n_pass++;
        ex_rd = '0; ex_wr = 0; ex_load = 0; mem_rd = 5'd3; mem_wr = 1;
        #1;
`ifdef PIPE_FWD_EN
        n_total++; if (seg_en !== 5'b11111) $display("FAIL lu_fwd_en: got %b want 11111", seg_en); else n_pass++;
        tick();
        n_total++; if (fwd_a !== 2'b10) $display("FAIL lu_fwd_a: got %b want 10", fwd_a); else n_pass++;
`else
        n_total++; if (seg_en !== 5'b11100) $display("FAIL lu_en2: got %b want 11100", seg_en); else n_pass++;
        tick();
        exp_stall++;
        mem_wr = 0;
        #1;
        n_total++; if (seg_en !== 5'b11111) $display("FAIL lu_en3: got %b want 11111", seg_en); else n_pass++;
        tick();
        n_total++; if (fwd_a !== 2'b00) $display("FAIL lu_fwd_a: got %b want 00", fwd_a); else n_pass++;
`endif
        n_total++; if (stall_cnt !== 16'(exp_stall)) $display("FAIL lu_stall_cnt2: got %0d want %0d", stall_cnt, exp_stall); else n_pass++;
        refill();
    endtask

    task automatic test_alu_dep();
        ex_rd = 5'd5; ex_wr = 1; id_rt = 5'd5; id_use_rt = 1;
        #1;
`ifdef PIPE_FWD_EN
        n_total++; if (seg_en !== 5'b11111) $display("FAIL alu_en: got %b want 11111", seg_en); else n_pass++;
        tick();
        n_total++; if (fwd_b !== 2'b01) $display("FAIL alu_fwd_b: got %b want 01", fwd_b); else n_pass++;
        n_total++; if (fwd_a !== 2'b00) $display("FAIL alu_fwd_a: got %b want 00", fwd_a); else n_pass++;
`else
        n_total++; if (seg_en !== 5'b11100) $display("FAIL alu_en: got %b want 11100", seg_en); else n_pass++;
        tick();
        exp_stall++;
        ex_wr = 0; mem_rd = 5'd5; mem_wr = 1;
        #1;
        n_total++; if (seg_en !== 5'b11100) $display("FAIL alu_en2: got %b want 11100", seg_en); else n_pass++;
        tick();
        exp_stall++;
        mem_wr = 0;
        #1;
        n_total++; if (seg_en !== 5'b11111) $display("FAIL alu_en3: got %b want 11111", seg_en); else n_pass++;
        tick();
        n_total++; if (fwd_b !== 2'b00) $display("FAIL alu_fwd_b: got %b want 00", fwd_b); else n_pass++;
`endif
        n_total++; if (stall_cnt !== 16'(exp_stall)) $display("FAIL alu_stall_cnt: got %0d want %0d", stall_cnt, exp_stall); else n_pass++;
        refill();
        // Register 0 never creates a dependency
        ex_rd = '0; ex_wr = 1; ex_load = 1; id_rs = '0; id_use_rs = 1; mem_rd = '0; mem_wr = 1;
        #1;
        n_total++; if (seg_en !== 5'b11111) $display("FAIL r0_en: got %b want 11111", seg_en); else n_pass++;
        tick();
        n_total++; if (stall_cnt !== 16'(exp_stall)) $display("FAIL r0_stall_cnt: got %0d want %0d", stall_cnt, exp_stall); else n_pass++;
        refill();
    endtask

    task automatic test_branch();
        ex_cond = 1;
        #1;
        n_total++; if (pc_sel !== 1'b1) $display("FAIL br_pc_sel: got %b want 1", pc_sel); else n_pass++;
        n_total++; if (seg_en !== 5'b11111) $display("FAIL br_en: got %b want 11111", seg_en); else n_pass++;
        tick();
        ex_cond = 0;
        #1;
        n_total++; if (seg_vld !== 5'b11001) $display("FAIL br_vld: got %b want 11001", seg_vld); else n_pass++;
        n_total++; if (pc_sel !== 1'b0) $display("FAIL br_pc_sel_off: got %b want 0", pc_sel); else n_pass++;
        refill();
        // Branch together with a load-use hazard: the flush wins, no stall counted
        ex_cond = 1; ex_rd = 5'd3; ex_wr = 1; ex_load = 1; id_rs = 5'd3; id_use_rs = 1;
        #1;
        n_total++; if (seg_en !== 5'b11111) $display("FAIL brst_en: got %b want 11111", seg_en); else n_pass++;
        n_total++; if (pc_sel !== 1'b1) $display("FAIL brst_pc_sel: got %b want 1", pc_sel); else n_pass++;
        tick();
        n_total++; if (stall_cnt !== 16'(exp_stall)) $display("FAIL brst_stall_cnt: got %0d want %0d", stall_cnt, exp_stall); else n_pass++;
        refill();
    endtask

    task automatic test_mem_wait();
        mem_req = 1; mem_ready = 0; ex_cond = 1;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_total++; if (seg_en !== 5'b10000) $display("FAIL mw_en%0d: got %b want 10000", i, seg_en); else n_pass++;
            n_total++; if (pc_sel !== 1'b0) $display("FAIL mw_pc_sel%0d: got %b want 0", i, pc_sel); else n_pass++;
            tick();
        end
        exp_stall += 3;
        n_total++; if (stall_cnt !== 16'(exp_stall)) $display("FAIL mw_stall_cnt: got %0d want %0d", stall_cnt, exp_stall); else n_pass++;
        n_total++; if (seg_vld !== 5'b01111) $display("FAIL mw_vld: got %b want 01111", seg_vld); else n_pass++;
        mem_ready = 1;
        #1;
        n_total++; if (pc_sel !== 1'b1) $display("FAIL mw_release_pc_sel: got %b want 1", pc_sel); else n_pass++;
        tick();
        ex_cond = 0; mem_req = 0;
        #1;
        n_total++; if (seg_vld !== 5'b11001) $display("FAIL mw_release_vld: got %b want 11001", seg_vld); else n_pass++;
        n_total++; if (stall_cnt !== 16'(exp_stall)) $display("FAIL mw_release_cnt: got %0d want %0d", stall_cnt, exp_stall); else n_pass++;
        refill();
    endtask

    task automatic test_timeout();
        mem_req = 1; mem_ready = 0;
        #1;
        repeat (MEMTO - 1) tick();
        n_total++; if (state !== 2'b01) $display("FAIL to_state_pre: got %b want 01", state); else n_pass++;
        tick();
        n_total++; if (state !== 2'b11) $display("FAIL to_state: got %b want 11", state); else n_pass++;
        n_total++; if (mem_timeout !== 1'b1) $display("FAIL to_flag: got %b want 1", mem_timeout); else n_pass++;
        n_total++; if (seg_en !== 5'b00000) $display("FAIL to_en: got %b want 00000", seg_en); else n_pass++;
        run = 1;
        tick();
        run = 0;
        n_total++; if (state !== 2'b11) $display("FAIL to_sticky: got %b want 11", state); else n_pass++;
        rst = 1;
        tick();
        rst = 0;
        clear_inputs();
        exp_stall = 0;
    endtask

    task automatic test_async_reset();
        run = 1;
        tick();
        run = 0;
        repeat (5) tick();
        mem_req = 1; mem_ready = 0;
        repeat (2) tick();
        n_total++; if (stall_cnt !== 16'd2) $display("FAIL ar_stall_cnt: got %0d want 2", stall_cnt); else n_pass++;
        #2;
        rst = 1;
        #1;
        n_total++; if (state !== 2'b00) $display("FAIL ar_state: got %b want 00", state); else n_pass++;
        n_total++; if (seg_vld !== 5'b0) $display("FAIL ar_vld: got %b want 00000", seg_vld); else n_pass++;
        n_total++; if (seg_en !== 5'b0) $display("FAIL ar_en: got %b want 00000", seg_en); else n_pass++;
        n_total++; if (stall_cnt !== 16'd0) $display("FAIL ar_cnt: got %0d want 0", stall_cnt); else n_pass++;
        tick();
        rst = 0;
        clear_inputs();
    endtask

    task automatic test_halt();
        run = 1;
        tick();
        run = 0;
        repeat (5) tick();
        halt_req = 1;
        #1;
        n_total++; if (seg_en !== 5'b11110) $display("FAIL h_en: got %b want 11110", seg_en); else n_pass++;
        tick();
        halt_req = 0;
        #1;
        n_total++; if (state !== 2'b10) $display("FAIL h_state_drain: got %b want 10", state); else n_pass++;
        n_total++; if (seg_vld !== 5'b11000) $display("FAIL h_vld: got %b want 11000", seg_vld); else n_pass++;
        n_total++; if (seg_en !== 5'b11110) $display("FAIL h_drain_en: got %b want 11110", seg_en); else n_pass++;
        repeat (2) tick();
        n_total++; if (state !== 2'b10) $display("FAIL h_state_drain3: got %b want 10", state); else n_pass++;
        tick();
        n_total++; if (state !== 2'b11) $display("FAIL h_state_halt: got %b want 11", state); else n_pass++;
        n_total++; if (mem_timeout !== 1'b0) $display("FAIL h_timeout: got %b want 0", mem_timeout); else n_pass++;
        n_total++; if (seg_en !== 5'b00000) $display("FAIL h_halt_en: got %b want 00000", seg_en); else n_pass++;
        run = 1;
        tick();
        run = 0;
        #1;
        n_total++; if (state !== 2'b01) $display("FAIL h_resume_state: got %b want 01", state); else n_pass++;
        n_total++; if (seg_en !== 5'b11111) $display("FAIL h_resume_en: got %b want 11111", seg_en); else n_pass++;
        tick();
        n_total++; if (seg_vld !== 5'b00001) $display("FAIL h_resume_vld: got %b want 00001", seg_vld); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_load_use();
        test_alu_dep();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_async_reset();
        test_halt();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks done", n_pass, n_total);
        $fatal(1);
    end

endmodule
`default_nettype wire
